// File: rtl/alu_rq_pkg.sv
// Shared constants and types for the ALU result queue.
// The flag bit order is fixed as {Cout, Negative, Zero, Overflow}, from bit 3 down to bit 0.
package alu_rq_pkg;

  localparam int SEL_W     = 4;
  localparam int FLAG_W    = 4;
  localparam int DEF_WIDTH = 32;

  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] y;
    logic [SEL_W-1:0]     sel;
    logic [FLAG_W-1:0]    flags;
  } rq_entry_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic cout,
                                                   input logic neg,
                                                   input logic zero,
                                                   input logic ovf);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLAG_COUT] = cout;
    f[FLAG_NEG]  = neg;
    f[FLAG_ZERO] = zero;
    f[FLAG_OVF]  = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_rq_mem.sv
// Storage for the ALU result queue: a DEPTH-entry register array.
// Writes are synchronous; reads are asynchronous. The contents are not reset.
module alu_rq_mem #(
  parameter int DEPTH = 4,
  parameter int EW    = 40
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [EW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [EW-1:0]            rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// A FIFO that holds ALU result words and their flags, placed between the ALU and the writeback stage.
// Optional feature: when ALU_RQ_STICKY_EN is defined, the sticky flag register is built.
module alu_result_queue
  import alu_rq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_Y,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_Cout,
  input  logic                       in_Negative,
  input  logic                       in_Zero,
  input  logic                       in_Overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_Y,
  output logic [SEL_W-1:0]           out_sel,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       sticky_clr,
  output logic [FLAG_W-1:0]          sticky_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = WIDTH + SEL_W + FLAG_W;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [FLAG_W-1:0] in_flags;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;
  logic              push;
  logic              pop;

  // Handshake: a beat transfers on a side when valid && ready are both high at a rising edge.
  // Both ready and valid depend only on the registered count, so a full queue
  // refuses a push even if it pops in the same cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign in_flags = pack_flags(in_Cout, in_Negative, in_Zero, in_Overflow);
  assign wr_entry = {in_Y, in_sel, in_flags};

  alu_rq_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign out_Y     = rd_entry[EW-1 -: WIDTH];
  assign out_sel   = rd_entry[FLAG_W +: SEL_W];
  assign out_flags = rd_entry[FLAG_W-1:0];

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_RQ_STICKY_EN
  // A clear discards the old contents, but the flags of a push in the same cycle still land.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push ? in_flags : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end
`else
  logic sticky_unused;
  assign sticky_unused = sticky_clr;
  assign sticky_flags  = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue. It checks the DUT every cycle against a queue model,
// plus literal expectations worked out by hand.
module tb_alu_result_queue;
  import alu_rq_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_Y;
  logic [3:0]       in_sel;
  logic [3:0]       in_fl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_Y;
  logic [3:0]       out_sel;
  logic [3:0]       out_flags;
  logic [2:0]       count;
  logic             sticky_clr;
  logic [3:0]       sticky_flags;

  int errors = 0;
  int checks = 0;

  rq_entry_t  model_q[$];
  logic [3:0] sticky_m;

  alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_Y         (in_Y),
    .in_sel       (in_sel),
    .in_Cout      (in_fl[3]),
    .in_Negative  (in_fl[2]),
    .in_Zero      (in_fl[1]),
    .in_Overflow  (in_fl[0]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_Y        (out_Y),
    .out_sel      (out_sel),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: FIFO semantics plus the sticky OR
  always @(posedge clk) begin
    bit m_push, m_pop;
    rq_entry_t e;
    if (rst) begin
      model_q.delete();
      sticky_m = 4'b0000;
    end else begin
      m_push = in_valid && (model_q.size() < DEPTH);
      m_pop  = out_ready && (model_q.size() > 0);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) begin
        e.y = in_Y; e.sel = in_sel; e.flags = in_fl;
        model_q.push_back(e);
      end
`ifdef ALU_RQ_STICKY_EN
      if (sticky_clr)  sticky_m = m_push ? in_fl : 4'b0000;
      else if (m_push) sticky_m = sticky_m | in_fl;
`endif
    end
  end

  // scoreboard compare, on the falling edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("sb_count", 64'(count), 64'(model_q.size()));
      chk("sb_in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
      chk("sb_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      chk("sb_sticky", 64'(sticky_flags), 64'(sticky_m));
      if (model_q.size() != 0) begin
        chk("sb_out_Y", 64'(out_Y), 64'(model_q[0].y));
        chk("sb_out_sel", 64'(out_sel), 64'(model_q[0].sel));
        chk("sb_out_flags", 64'(out_flags), 64'(model_q[0].flags));
      end
    end
  end

  // driver: apply inputs for one clock edge, then return at posedge+2
  task automatic step(input logic iv, input logic [31:0] y, input logic [3:0] sel,
                      input logic [3:0] fl, input logic ordy, input logic clr);
    in_valid = iv; in_Y = y; in_sel = sel; in_fl = fl;
    out_ready = ordy; sticky_clr = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 4'h0, 4'h0, ordy, 1'b0);
  endtask

  logic [3:0] exp_sticky;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_Y = '0; in_sel = '0; in_fl = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);

    // single push, then hold while stalled
    step(1'b1, 32'h0000_0005, 4'b0110, 4'b0000, 1'b0, 1'b0);
    chk("push1_valid", 64'(out_valid), 64'd1);
    chk("push1_Y", 64'(out_Y), 64'h5);
    chk("push1_sel", 64'(out_sel), 64'h6);
    chk("push1_count", 64'(count), 64'd1);
    repeat (3) idle(1'b0);
    chk("hold_Y", 64'(out_Y), 64'h5);
    chk("hold_count", 64'(count), 64'd1);
    idle(1'b1);
    chk("pop1_count", 64'(count), 64'd0);

    // fill, push while full, then drain
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 4'(i), 4'h0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'd99, 4'hf, 4'h0, 1'b0, 1'b0);
    chk("full_ignored_count", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_Y", 64'(out_Y), 64'(i));
      idle(1'b1);
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // wrap the pointers
    for (int i = 10; i <= 13; i++) step(1'b1, 32'(i), 4'h3, 4'h0, 1'b0, 1'b0);
    for (int i = 10; i <= 13; i++) begin
      chk("wrap_Y", 64'(out_Y), 64'(i));
      idle(1'b1);
    end

    // push and pop in the same cycle with count = 2
    step(1'b1, 32'd7, 4'h1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 32'd8, 4'h2, 4'h0, 1'b0, 1'b0);
    step(1'b1, 32'd9, 4'h3, 4'h0, 1'b1, 1'b0);
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head", 64'(out_Y), 64'd8);
    idle(1'b1);
    chk("pp_next", 64'(out_Y), 64'd9);
    idle(1'b1);

    // sticky flags
    step(1'b1, 32'd20, 4'h0, 4'b1000, 1'b1, 1'b0);
    step(1'b1, 32'd21, 4'h0, 4'b0001, 1'b1, 1'b0);
`ifdef ALU_RQ_STICKY_EN
    exp_sticky = 4'b1001;
`else
    exp_sticky = 4'b0000;
`endif
    chk("sticky_or", 64'(sticky_flags), 64'(exp_sticky));
    chk("sticky_head_flags", 64'(out_flags), 64'b0001);
    step(1'b1, 32'd22, 4'h0, 4'b0100, 1'b1, 1'b1);
`ifdef ALU_RQ_STICKY_EN
    exp_sticky = 4'b0100;
`else
    exp_sticky = 4'b0000;
`endif
    chk("sticky_clr_push", 64'(sticky_flags), 64'(exp_sticky));
    step(1'b0, 32'd0, 4'h0, 4'b0000, 1'b1, 1'b1);
    chk("sticky_clr_only", 64'(sticky_flags), 64'd0);
    idle(1'b1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 32'(30 + i), 4'h5, 4'b0110, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sticky", 64'(sticky_flags), 64'd0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
